// File: rtl/anf_pkg.sv
// Shared types, sizing helpers and popcount for the ANF streaming output block.
package anf_pkg;

    function automatic int unsigned idx_width(input int unsigned n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

    function automatic int unsigned deg_width(input int unsigned log2_n);
        return $clog2(log2_n + 1);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) c += 32'(v[i]);
        return c;
    endfunction

    localparam int unsigned N_DEF      = 2048;
    localparam int unsigned LOG2_N_DEF = 11;
    localparam int unsigned W_DEF      = 32;
    localparam int unsigned N_WORDS    = N_DEF / W_DEF;
    localparam int unsigned WIDX_W     = idx_width(N_WORDS);
    localparam int unsigned DEG_W      = deg_width(LOG2_N_DEF);

    typedef enum logic {IDLE, STREAM} state_e;

endpackage

// File: rtl/anf_word_degree.sv
// Combinational: highest monomial degree among the set bits of one W-bit ANF word at index k.
module anf_word_degree
    import anf_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned DEG_BITS = 4
) (
    input  logic [W-1:0]        word,
    input  logic [IDX_BITS-1:0] k,
    output logic [DEG_BITS-1:0] max_deg,
    output logic                any_set
);

    logic [DEG_BITS-1:0] bit_deg;

    always_comb begin
        max_deg = '0;
        any_set = 1'b0;
        bit_deg = '0;
        for (int unsigned b = 0; b < W; b++) begin
            bit_deg = DEG_BITS'(popcount(32'(k) * W + b));
            if (word[b]) begin
                any_set = 1'b1;
                if (bit_deg > max_deg) max_deg = bit_deg;
            end
        end
    end

endmodule

// File: rtl/anf_stream_out.sv
// Captures an N-bit ANF vector and streams it as W-bit words over valid/ready.
// Define ANF_DEGREE_EN to add the deg/deg_valid algebraic-degree outputs.
module anf_stream_out
    import anf_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned LOG2_N = LOG2_N_DEF,
    parameter int unsigned W      = W_DEF,
    localparam int unsigned NUM_WORDS = (1 << LOG2_N) / W,
    localparam int unsigned IDX_BITS  = idx_width(NUM_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:N-1]        anf,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [IDX_BITS-1:0] out_idx,
    output logic                out_last,
    output logic                busy
`ifdef ANF_DEGREE_EN
    ,
    output logic [deg_width(LOG2_N)-1:0] deg,
    output logic                         deg_valid
`endif
);

    state_e                       state_q, state_d;
    logic [NUM_WORDS-1:0][W-1:0]  cap_q;
    logic [N-1:0]                 anf_flat;
    logic [IDX_BITS-1:0]          word_q, word_d;
    logic                         capture, beat, last_word;

    // anf is declared ascending; flatten so bit i of the capture is anf[i].
    for (genvar i = 0; i < N; i++) begin : g_flat
        assign anf_flat[i] = anf[i];
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == STREAM);
    assign busy      = out_valid;
    assign capture   = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign last_word = (word_q == IDX_BITS'(NUM_WORDS - 1));

    assign out_data = cap_q[word_q];
    assign out_idx  = word_q;
    assign out_last = out_valid && last_word;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = STREAM;
                    word_d  = '0;
                end
            end
            STREAM: begin
                if (beat) begin
                    if (last_word) begin
                        state_d = IDLE;
                        word_d  = '0;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            if (capture) cap_q <= anf_flat;
        end
    end

`ifdef ANF_DEGREE_EN
    localparam int unsigned DEG_BITS = deg_width(LOG2_N);

    logic [DEG_BITS-1:0] word_deg, deg_q;
    logic                word_any, deg_valid_q;

    anf_word_degree #(
        .W        (W),
        .IDX_BITS (IDX_BITS),
        .DEG_BITS (DEG_BITS)
    ) u_word_degree (
        .word    (out_data),
        .k       (word_q),
        .max_deg (word_deg),
        .any_set (word_any)
    );

    // Degree tracks the beats as they are accepted, so the stream never waits on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deg_q       <= '0;
            deg_valid_q <= 1'b0;
        end else begin
            deg_valid_q <= beat && last_word;
            if (capture) begin
                deg_q <= '0;
            end else if (beat && word_any && (word_deg > deg_q)) begin
                deg_q <= word_deg;
            end
        end
    end

    assign deg       = deg_q;
    assign deg_valid = deg_valid_q;
`endif

endmodule

// File: tb/tb_anf_stream_out.sv
// Directed bench for anf_stream_out: small N=16/W=4 instance plus an N=2048/W=32 instance.
module tb_anf_stream_out;

    localparam int unsigned N  = 16;
    localparam int unsigned LN = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned BN = 2048;
    localparam int unsigned BL = 11;
    localparam int unsigned BW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [0:N-1]  anf;
    logic [W-1:0]  out_data;
    logic [1:0]    out_idx;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [0:BN-1] b_anf;
    logic [BW-1:0] b_out_data;
    logic [5:0]    b_out_idx;
`ifdef ANF_DEGREE_EN
    logic [2:0]    deg;
    logic          deg_valid;
    logic [3:0]    b_deg;
    logic          b_deg_valid;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    anf_stream_out #(.N(N), .LOG2_N(LN), .W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .anf       (anf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
`ifdef ANF_DEGREE_EN
        ,
        .deg       (deg),
        .deg_valid (deg_valid)
`endif
    );

    anf_stream_out #(.N(BN), .LOG2_N(BL), .W(BW)) u_dut_big (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .anf       (b_anf),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_idx   (b_out_idx),
        .out_last  (b_out_last),
        .busy      (b_busy)
`ifdef ANF_DEGREE_EN
        ,
        .deg       (b_deg),
        .deg_valid (b_deg_valid)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Present v (word k = v[4k+3:4k]) and wait for capture; leaves in_valid high if hold.
    task automatic send(input logic [15:0] v, input bit hold);
        int t;
        t = 0;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) anf[i] = v[i];
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("send_ready", in_ready, 1'b1);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        check_eq("capture_busy", busy, 1'b1);
    endtask

    // Drain one vector; bp=1 drives out_ready as 1,0,0,1,0,0,...
    task automatic collect(input bit bp, input logic [15:0] v, input int exp_deg);
        int          beats, cyc;
        bit          stalled;
        logic [3:0]  prev_data;
        logic [1:0]  prev_idx;
        logic        prev_last;
        beats = 0; cyc = 0; stalled = 1'b0;
        prev_data = '0; prev_idx = '0; prev_last = 1'b0;
        while (beats < 4 && cyc < 100) begin
            out_ready = !bp || (cyc % 3 == 0);
            check_eq("valid_hold", out_valid, 1'b1);
            check_eq("ready_low", in_ready, 1'b0);
            if (stalled) begin
                check_eq("stall_data", out_data, prev_data);
                check_eq("stall_idx", out_idx, prev_idx);
                check_eq("stall_last", out_last, prev_last);
            end
            if (out_ready) begin
                check_eq("beat_data", out_data, v[4*beats +: 4]);
                check_eq("beat_idx", out_idx, beats);
                check_eq("beat_last", out_last, beats == 3);
                beats++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                prev_data = out_data;
                prev_idx  = out_idx;
                prev_last = out_last;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("beat_count", beats, 4);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_valid", out_valid, 1'b0);
`ifdef ANF_DEGREE_EN
        check_eq("deg_valid", deg_valid, 1'b1);
        check_eq("deg", deg, exp_deg);
`else
        if (exp_deg < 0) $display("unexpected degree argument");
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit          a[BN];
        logic [31:0] w;
        int          beats, cyc, exp_bdeg;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; anf = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_anf = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 4'h0);
        check_eq("rst_out_idx", out_idx, 2'd0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
`ifdef ANF_DEGREE_EN
        check_eq("rst_deg", deg, 3'd0);
        check_eq("rst_deg_valid", deg_valid, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1'b1);

        // Reset mid-stream discards the partial vector
        send(16'hFFFF, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", out_valid, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_idx", out_idx, 2'd0);
        check_eq("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("midrst_after_ready", in_ready, 1'b1);
        check_eq("midrst_after_valid", out_valid, 1'b0);
        check_eq("midrst_after_data", out_data, 4'h0);

        // Corner monomials 1 and x0x1x2x3
        send(16'h8001, 1'b0);
        collect(1'b0, 16'h8001, 4);

        // Backpressure
        send(16'h635A, 1'b0);
        collect(1'b1, 16'h635A, 3);

        // in_valid held across two vectors: second is taken only in the IDLE cycle
        send(16'h4321, 1'b1);
        for (int i = 0; i < N; i++) anf[i] = 16'hCDEF >> i;
        collect(1'b0, 16'h4321, 3);
        check_eq("b2b_idle_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("b2b_second_busy", busy, 1'b1);
        collect(1'b0, 16'hCDEF, 4);

        // All-zero ANF and a single degree-2 monomial
        send(16'h0000, 1'b0);
        collect(1'b0, 16'h0000, 0);
        @(negedge clk);
`ifdef ANF_DEGREE_EN
        check_eq("deg_pulse_once", deg_valid, 1'b0);
        check_eq("deg_hold", deg, 3'd0);
`endif
        send(16'h0008, 1'b0);
        collect(1'b0, 16'h0008, 2);

        // N=2048, W=32: Mobius transform of a random truth table
        for (int x = 0; x < BN; x++) a[x] = 1'($urandom_range(0, 1));
        for (int i = 0; i < BL; i++)
            for (int x = 0; x < BN; x++)
                if ((x >> i) & 1) a[x] = a[x] ^ a[x ^ (1 << i)];
        exp_bdeg = 0;
        for (int x = 0; x < BN; x++)
            if (a[x] && $countones(x) > exp_bdeg) exp_bdeg = $countones(x);
        for (int i = 0; i < BN; i++) b_anf[i] = a[i];
        b_in_valid = 1'b1;
        cyc = 0;
        while (!b_in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("big_send_ready", b_in_ready, 1'b1);
        @(negedge clk);
        b_in_valid = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 64 && cyc < 1000) begin
            b_out_ready = 1'($urandom_range(0, 1));
            if (b_out_valid && b_out_ready) begin
                for (int b = 0; b < BW; b++) w[b] = a[beats*BW + b];
                check_eq("big_data", b_out_data, w);
                check_eq("big_idx", b_out_idx, beats);
                check_eq("big_last", b_out_last, beats == 63);
                beats++;
            end
            cyc++;
            @(negedge clk);
        end
        b_out_ready = 1'b0;
        check_eq("big_beat_count", beats, 64);
        check_eq("big_idle", b_busy, 1'b0);
`ifdef ANF_DEGREE_EN
        check_eq("big_deg_valid", b_deg_valid, 1'b1);
        check_eq("big_deg", b_deg, exp_bdeg);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
